// File: rtl/prbs_tx_sequencer.sv
// ---------------------------------------------------------------------------
// prbs_tx_sequencer
//
// Transmit side of the PRBS9 BER test link. Produces the PRBS9 stream
// (x^9 + x^5 + 1) at baud rate, one bit per i_ctrl strobe, and runs the
// test-sequencing FSM that steers the BER checker: IDLE, a latency-search
// sweep (SYNC), then BER counting.
//
// The sweep walks PRBS_MAX_CYCLES windows of PRBS_MAX_CYCLES bits each; the
// checker uses o_sync_addr and o_prbs_cmp_curr_addr_done to try one candidate
// delay per window.
//
// Ports:
//   clk                        system clock
//   i_reset                    synchronous active-high reset
//   i_en_tx                    transmit enable; low behaves as a sync reset
//   i_ctrl                     baud strobe, one clk wide; all progress gated
//   i_start                    level; launches the sweep from IDLE
//   i_stop                     level; aborts SYNC / ends BER, back to IDLE
//   o_tx_bit                   current PRBS bit (channel + checker reference)
//   o_synchro_en               high while in SYNC
//   o_prbs_cmp_curr_addr_done  high during the last bit of each sweep window
//   o_ber_counter_en           high while in BER
//   o_sync_addr                current sweep window index
//   o_busy                     high in SYNC or BER
// ---------------------------------------------------------------------------
module prbs_tx_sequencer #(
    parameter int          PRBS_MAX_CYCLES = 511,
    parameter logic [8:0]  SEED            = 9'h1AA,
    localparam int         CNT_W           = (PRBS_MAX_CYCLES > 1) ? $clog2(PRBS_MAX_CYCLES) : 1
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_en_tx,
    input  logic             i_ctrl,
    input  logic             i_start,
    input  logic             i_stop,
    output logic             o_tx_bit,
    output logic             o_synchro_en,
    output logic             o_prbs_cmp_curr_addr_done,
    output logic             o_ber_counter_en,
    output logic [CNT_W-1:0] o_sync_addr,
    output logic             o_busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_BER  = 2'd2;

    // Terminal count for both counters. Compared explicitly so that
    // non-power-of-two sizes terminate correctly instead of wrapping.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRBS_MAX_CYCLES - 1);

    logic [8:0]       lfsr;
    logic [8:0]       lfsr_next;
    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_next;
    logic [CNT_W-1:0] addr_cnt;
    logic [CNT_W-1:0] addr_cnt_next;
    logic             window_done;
    logic             sync_rst;

    // Either reset source returns everything to the power-up state.
    assign sync_rst = i_reset | ~i_en_tx;

    assign window_done = (state == ST_SYNC) && (bit_cnt == CNT_LAST);

    // Fibonacci shift toward the MSB; the feedback taps are stages 9 and 5.
    assign lfsr_next = {lfsr[7:0], lfsr[8] ^ lfsr[4]};

    // Next-state logic; only consulted on a baud strobe.
    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        addr_cnt_next = addr_cnt;

        case (state)
            ST_IDLE: begin
                // Stop has priority over a simultaneous start.
                if (!i_stop && i_start) begin
                    state_next    = ST_SYNC;
                    bit_cnt_next  = '0;
                    addr_cnt_next = '0;
                end
            end

            ST_SYNC: begin
                if (i_stop) begin
                    // Abort wins over the window/sweep completion.
                    state_next    = ST_IDLE;
                    bit_cnt_next  = '0;
                    addr_cnt_next = '0;
                end else if (window_done) begin
                    bit_cnt_next = '0;
                    if (addr_cnt == CNT_LAST) begin
                        state_next    = ST_BER;
                        addr_cnt_next = '0;
                    end else begin
                        addr_cnt_next = addr_cnt + 1'b1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt + 1'b1;
                end
            end

            ST_BER: begin
                bit_cnt_next  = '0;
                addr_cnt_next = '0;
                if (i_stop) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next    = ST_IDLE;
                bit_cnt_next  = '0;
                addr_cnt_next = '0;
            end
        endcase
    end

    // Register stage: everything advances only on the baud strobe.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            lfsr     <= SEED;
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            addr_cnt <= '0;
        end else if (i_ctrl) begin
            lfsr     <= lfsr_next;
            state    <= state_next;
            bit_cnt  <= bit_cnt_next;
            addr_cnt <= addr_cnt_next;
        end
    end

    // Outputs are decoded straight from the registers (no extra latency).
    assign o_tx_bit                  = lfsr[8];
    assign o_synchro_en              = (state == ST_SYNC);
    assign o_prbs_cmp_curr_addr_done = window_done;
    assign o_ber_counter_en          = (state == ST_BER);
    assign o_sync_addr               = addr_cnt;
    assign o_busy                    = (state != ST_IDLE);

endmodule
